instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Boot-time writer for instruction memory; the CPU only ever reads that memory.
//  - Takes a byte stream over a valid/ready handshake: 16-bit word count, then little-endian 32-bit words.
//  - Writes the words to consecutive word addresses.
//  - Holds the CPU in reset until the image is fully loaded.
//  - Sits between the host/debug byte source and the write port of instr_mem.
// PARAMETERS
//  MEM_WORDS  64   instruction memory capacity in 32-bit words; larger counts are rejected
//  BASE_ADDR  0    byte address of the first word written; must be 4-byte aligned
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  start         in   1   one-cycle pulse; restarts a load from DONE or ERR
//  in_valid      in   1   in_byte is valid this cycle
//  in_byte       in   8   stream byte
//  in_ready      out  1   loader accepts in_byte this cycle
//  wr_en         out  1   one-cycle instruction-memory write strobe
//  wr_addr       out  32  byte address of the write, 4-byte aligned
//  wr_data       out  32  instruction word {b3,b2,b1,b0}
//  cpu_hold      out  1   1 = keep CPU in reset
//  done          out  1   load completed successfully (level)
//  error         out  1   load aborted (level)
//  words_loaded  out  16  number of words written so far
// BEHAVIOUR
//  - Reset (rst=0, async): state=HDR_LO; cpu_hold=1.
//    All other outputs are 0: in_ready, wr_en, wr_addr, wr_data, done, error, words_loaded.
//    Byte counter and word counter are cleared.
//  - Handshake: a byte is accepted when in_valid && in_ready at a rising edge.
//    in_ready is a registered level: 1 in HDR_LO, HDR_HI, DATA and CKSUM; 0 in DONE and ERR.
//  - State HDR_LO: the accepted byte becomes count[7:0]. Next state: HDR_HI.
//  - State HDR_HI: the accepted byte becomes count[15:8]. Then:
//      count==0          -> DONE
//      count>MEM_WORDS   -> ERR
//      otherwise         -> DATA
//  - State DATA: bytes are assembled LSB first.
//    On accepting the 4th byte of word i, the next cycle has:
//      wr_en=1
//      wr_addr = BASE_ADDR + 4*i (32-bit arithmetic, no wrap check needed because of the count limit)
//      wr_data = {b3,b2,b1,b0}
//      words_loaded = i+1
//  - wr_en is high for exactly one cycle per word. wr_addr and wr_data hold their values until the next write.
//  - After the last word:
//      go to CKSUM when the checksum macro is defined
//      otherwise go to DONE on the same edge that raises wr_en
//    In the no-checksum case, done and the final wr_en are high in the same cycle.
//  - cpu_hold = 1 in every state except DONE. It drops on the same edge that done rises.
//  - DONE and ERR are sticky:
//      in_valid is ignored
//      start -> HDR_LO; clears counters, done, error and words_loaded; sets cpu_hold=1
//  - start in HDR_LO, HDR_HI, DATA or CKSUM is ignored; an active load is never aborted by start.
//  - start and in_valid in the same cycle in DONE/ERR: start is taken and the byte is not accepted (in_ready=0).
//  - Reset during a load: the load is abandoned immediately.
//    Words already written stay in memory; words_loaded reads 0.
//  - Partial word in flight when the stream stalls: no timeout. The loader waits indefinitely and no write occurs.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined:
//    - An 8-bit sum (mod 256) is taken over all data bytes; header bytes are excluded.
//    - After the last word, state CKSUM accepts one byte. Equal to the sum -> DONE; otherwise -> ERR.
//    - With count==0 there is no CKSUM byte.
//    - All words are written before the compare, so memory holds the image even on ERR, but cpu_hold stays 1.
//  - LOADER_CHECKSUM_EN undefined: there is no CKSUM state and no adder; the load ends after the last word.
// TESTING
//  - Reset values: after reset, check cpu_hold=1, in_ready=1, and done=error=wr_en=words_loaded=0.
//  - 2-word load, no checksum:
//    - Stream 02 00 | 13 05 10 00 | 93 05 20 00.
//    - Expect wr_en @0x0 with 0x00100513, then @0x4 with 0x00200593.
//    - In the final-write cycle: done=1 and cpu_hold=0; words_loaded=2.
//  - Over-size header: stream 41 00 with MEM_WORDS=64 -> error=1, in_ready=0, no wr_en, cpu_hold=1.
//  - Checksum (LOADER_CHECKSUM_EN):
//    - The 1-word load 01 00 | 01 02 03 04 has sum 0x0A.
//    - Checksum byte 0A -> done=1. Checksum byte 0B -> error=1, cpu_hold=1, one wr_en of 0x04030201 seen.
//  - Backpressure and stalls:
//    - Random in_valid gaps during DATA still give correct word assembly.
//    - In DONE, start asserted with in_valid=1 -> byte not accepted, state HDR_LO, cpu_hold=1.
//  - Reset mid-word: apply rst=0 after 2 of 4 data bytes -> no wr_en; all outputs return to their reset values.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time instruction-memory writer: receives a byte stream (16-bit word count, then little-endian
// words), writes the words to consecutive addresses and holds the CPU in reset until the image is in.
// Optional trailing checksum byte check is enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic [2:0]  state_dbg
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is a
    // registered level derived from the next state, so it never depends combinationally on in_valid.

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CKSUM  = 3'd3,
`endif
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [16:0] MAX_COUNT = 17'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    logic        fire;
    logic [15:0] hdr_count;
    logic        last_byte;
    logic        last_word;
    logic        restart;

    assign fire      = in_valid && in_ready;
    assign hdr_count = {in_byte, count_q[7:0]};
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = ((words_loaded + 16'd1) == count_q);
    assign restart   = start && (state_q == DONE || state_q == ERR);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_LO: if (fire) state_d = HDR_HI;
            HDR_HI: begin
                if (fire) begin
                    if (hdr_count == 16'd0)
                        state_d = DONE;
                    else if ({1'b0, hdr_count} > MAX_COUNT)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (fire && last_byte && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CKSUM: if (fire) state_d = (in_byte == sum_q) ? DONE : ERR;
`endif
            DONE, ERR: if (start) state_d = HDR_LO;
            default: state_d = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HDR_LO;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= 32'd0;
            wr_data      <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            count_q      <= 16'd0;
            byte_cnt     <= 2'd0;
            byte_buf     <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            // Status flags are registered from the next state so they change on the same edge as the state.
            state_q  <= state_d;
            in_ready <= !(state_d == DONE || state_d == ERR);
            done     <= (state_d == DONE);
            error    <= (state_d == ERR);
            cpu_hold <= (state_d != DONE);
            wr_en    <= 1'b0;

            if (restart) begin
                words_loaded <= 16'd0;
                count_q      <= 16'd0;
                byte_cnt     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                sum_q        <= 8'd0;
`endif
            end

            if (fire) begin
                case (state_q)
                    HDR_LO: count_q[7:0]  <= in_byte;
                    HDR_HI: count_q[15:8] <= in_byte;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q    <= sum_q + in_byte;
`endif
                        // Bytes shift in from the top, so after three bytes byte_buf = {b2,b1,b0}.
                        if (last_byte) begin
                            wr_en        <= 1'b1;
                            wr_data      <= {in_byte, byte_buf};
                            wr_addr      <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                            words_loaded <= words_loaded + 16'd1;
                        end else begin
                            byte_buf <= {in_byte, byte_buf[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and randomized loads against a byte-stream
// reference model and an expected-write queue. Honours LOADER_CHECKSUM_EN when defined.
module tb_instr_mem_loader;

    localparam int          MEM_WORDS = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [2:0]  ST_HDR_LO = 3'd0;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    logic [2:0]  state_dbg;

    instr_mem_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          writes_seen = 0;
    logic        last_wr_done;
    logic        last_wr_hold;
    logic [79:0] exp_q[$];          // {addr, data, words_loaded}
    logic [31:0] img[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && wr_en === 1'b1) begin
            logic [79:0] e;
            writes_seen++;
            last_wr_done = done;
            last_wr_hold = cpu_hold;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e[79:48]));
                chk("wr_data", 64'(wr_data), 64'(e[47:16]));
                chk("words_loaded_at_wr", 64'(words_loaded), 64'(e[15:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        logic acc;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        acc      = 1'b0;
        for (int t = 0; t < 200; t++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Reference model: builds the byte stream for the image in img, predicts every write and the
    // final status, then streams it with random gaps and checks the end state.
    task automatic load_image(input logic [15:0] cnt, input int max_gap, input bit corrupt_ck,
                              input string tag);
        logic [7:0]  stream[$];
        logic [7:0]  s;
        logic [7:0]  b;
        logic [31:0] w;
        bit          ok;
        bit          exp_done;
        int          writes_before;
        s  = 8'd0;
        ok = (cnt != 16'd0) && (int'(cnt) <= MEM_WORDS);
        stream.push_back(cnt[7:0]);
        stream.push_back(cnt[15:8]);
        if (ok) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    stream.push_back(b);
                    s = s + b;
                end
                exp_q.push_back({BASE_ADDR + 32'(4 * i), w, 16'(i + 1)});
            end
        end
        exp_done = (cnt == 16'd0) || ok;
`ifdef LOADER_CHECKSUM_EN
        if (ok) stream.push_back(corrupt_ck ? (s ^ 8'h01) : s);
        if (ok && corrupt_ck) exp_done = 1'b0;
`else
        if (corrupt_ck) s = 8'd0;
`endif
        writes_before = writes_seen;
        foreach (stream[i]) send_byte(stream[i], max_gap);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(!exp_done));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), ok ? 64'(cnt) : 64'd0);
        chk({tag, "_write_count"}, 64'(writes_seen - writes_before), ok ? 64'(cnt) : 64'd0);
        chk({tag, "_exp_q_drained"}, 64'(exp_q.size()), 64'd0);
`ifndef LOADER_CHECKSUM_EN
        if (ok) begin
            chk({tag, "_done_with_last_wr"}, 64'(last_wr_done), 64'd1);
            chk({tag, "_hold_low_with_last_wr"}, 64'(last_wr_hold), 64'd0);
        end
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int wr_before;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        // Reset values while reset is held
        #12;
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_words_loaded", 64'(words_loaded), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_state", 64'(state_dbg), 64'(ST_HDR_LO));
        chk("post_rst_cpu_hold", 64'(cpu_hold), 64'd1);

        // 2-word directed load: 02 00 | 13 05 10 00 | 93 05 20 00
        img.delete();
        img.push_back(32'h0010_0513);
        img.push_back(32'h0020_0593);
        load_image(16'd2, 0, 1'b0, "two_word");

        // start together with in_valid in DONE: start wins, byte dropped
        start    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("restart_words_loaded", 64'(words_loaded), 64'd0);
        chk("restart_state", 64'(state_dbg), 64'(ST_HDR_LO));
        chk("restart_in_ready", 64'(in_ready), 64'd1);
        fill_random(1);
        load_image(16'd1, 2, 1'b0, "after_restart");

        // Over-size header 41 00
        pulse_start();
        load_image(16'h0041, 0, 1'b0, "oversize");

        // Empty image 00 00
        pulse_start();
        load_image(16'd0, 0, 1'b0, "zero_count");

`ifdef LOADER_CHECKSUM_EN
        img.delete();
        img.push_back(32'h0403_0201);
        pulse_start();
        load_image(16'd1, 0, 1'b0, "cksum_good");
        pulse_start();
        load_image(16'd1, 0, 1'b1, "cksum_bad");
`endif

        // Random loads with stalls, including the exact capacity boundary
        for (int n = 0; n < 4; n++) begin
            int cnt;
            cnt = int'($urandom_range(9, 1));
            fill_random(cnt);
            pulse_start();
            load_image(16'(cnt), 3, 1'($urandom_range(1, 0)), "random");
        end
        fill_random(MEM_WORDS);
        pulse_start();
        load_image(16'(MEM_WORDS), 1, 1'b0, "full_capacity");

        // Reset mid-word: header + 2 data bytes, then async reset
        pulse_start();
        wr_before = writes_seen;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        rst = 1'b0;
        #1;
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        chk("midrst_words_loaded", 64'(words_loaded), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_no_write", 64'(writes_seen - wr_before), 64'd0);
        chk("midrst_state", 64'(state_dbg), 64'(ST_HDR_LO));
        chk("midrst_ready_again", 64'(in_ready), 64'd1);

        // A fresh load straight after reset must work from word 0
        fill_random(3);
        load_image(16'd3, 2, 1'b0, "post_midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
